// File: rtl/rect_stream_dma.sv
// rect_stream_dma: five-pass rectangle DMA that resolves, clamps and streams rectangle fields to a GPU
module rect_stream_dma #(
  parameter int COORD_WIDTH = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int RECT_ADDR   = 256,
  parameter int N_RECTS     = 64,
  parameter int BATCH_SIZE  = 16,
  parameter int RECT_WORDS  = 6,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  copy_start,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [15:0]           mem_rd_data,
  output logic [15:0]           dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [2:0]            dout_field,
  input  logic                  batch_ack,
  output logic                  busy,
  output logic                  done
);
  localparam int CW = COORD_WIDTH;
  localparam int IW = $clog2(N_RECTS + 1);
  localparam int BW = $clog2(BATCH_SIZE + 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(RECT_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(RECT_WORDS);
  localparam logic [2:0] S_IDLE = 3'd0, S_FLAG = 3'd1, S_A = 3'd2, S_B = 3'd3,
                         S_CALC = 3'd4, S_EMIT = 3'd5, S_BWAIT = 3'd6, S_DONE = 3'd7;
  logic [2:0] state_q, state_d, field_q, field_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic abs_q, abs_d, valid_q, valid_d;
  logic [CW-1:0] cursor_q, cursor_d, coord_q, coord_d;
  logic [15:0] dout_q, dout_d;
  logic [CW-1:0] rd, coord, base, val, lim, clamped;
  logic has_b, is_x, last_b;
  always_comb begin
    rd      = mem_rd_data[CW-1:0];
    has_b   = field_q == 3'd1 || field_q == 3'd3;
    is_x    = field_q < 3'd2;
    coord   = has_b ? coord_q : rd;
    base    = abs_q ? coord : cursor_q + coord;
    val     = has_b ? base + rd : base;
    lim     = is_x ? CW'(SCREEN_W) : CW'(SCREEN_H);
    clamped = val[CW-1] ? '0 : (val >= lim ? lim : val);
    last_b  = bcnt_q == BW'(BATCH_SIZE - 1);
    state_d  = state_q;
    field_d  = field_q;
    addr_d   = addr_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    abs_d    = abs_q;
    valid_d  = valid_q;
    cursor_d = cursor_q;
    coord_d  = coord_q;
    dout_d   = dout_q;
    case (state_q)
      S_IDLE: if (copy_start) begin
        state_d  = S_FLAG;
        field_d  = 3'd0;
        addr_d   = BASE;
        ptr_d    = BASE;
        idx_d    = '0;
        bcnt_d   = '0;
        abs_d    = 1'b0;
        cursor_d = '0;
      end
      S_FLAG: begin
        state_d = S_A;
        addr_d  = ptr_q + (field_q == 3'd4 ? ADDR_WIDTH'(5) : is_x ? ADDR_WIDTH'(1) : ADDR_WIDTH'(2));
      end
      S_A: begin
        abs_d   = mem_rd_data[0];
        state_d = has_b ? S_B : S_CALC;
        addr_d  = has_b ? ptr_q + (field_q == 3'd1 ? ADDR_WIDTH'(3) : ADDR_WIDTH'(4)) : addr_q;
      end
      S_B: begin
        coord_d = rd;
        state_d = S_CALC;
      end
      S_CALC: begin
        dout_d   = field_q == 3'd4 ? mem_rd_data : 16'(clamped);
        valid_d  = 1'b1;
        cursor_d = field_q != 3'd4 && abs_q ? coord : cursor_q;
        state_d  = S_EMIT;
      end
      S_EMIT: if (dout_ready) begin
        valid_d = 1'b0;
        idx_d   = idx_q + IW'(1);
        ptr_d   = ptr_q + STEP;
        bcnt_d  = last_b ? '0 : bcnt_q + BW'(1);
        state_d = last_b ? S_BWAIT : S_FLAG;
        addr_d  = last_b ? addr_q : ptr_q + STEP;
      end
      S_BWAIT: if (batch_ack) begin
        if (idx_q == IW'(N_RECTS)) begin
          state_d  = field_q == 3'd4 ? S_DONE : S_FLAG;
          field_d  = field_q == 3'd4 ? field_q : field_q + 3'd1;
          idx_d    = '0;
          ptr_d    = BASE;
          addr_d   = BASE;
          cursor_d = '0;
        end else begin
          state_d = S_FLAG;
          addr_d  = ptr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      field_q  <= 3'd0;
      addr_q   <= BASE;
      ptr_q    <= BASE;
      idx_q    <= '0;
      bcnt_q   <= '0;
      abs_q    <= 1'b0;
      valid_q  <= 1'b0;
      cursor_q <= '0;
      coord_q  <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      addr_q   <= addr_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      abs_q    <= abs_d;
      valid_q  <= valid_d;
      cursor_q <= cursor_d;
      coord_q  <= coord_d;
      dout_q   <= dout_d;
    end
  end
  assign mem_rd_addr = addr_q;
  assign dout        = dout_q;
  assign dout_valid  = valid_q;
  assign dout_field  = field_q;
  assign busy        = state_q != S_IDLE;
  assign done        = state_q == S_DONE;
endmodule
